// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - bus widths for IF->ID and the branch redirect bus
//   - bit offsets of the fields inside those buses
//   - flush-target select encoding and the priority function that picks it
package if_pkg;

  localparam int IF_TO_ID_BUS_W = 65;
  localparam int BR_BUS_W       = 33;

  // IF_to_ID_bus = {inst[31:0], pc[31:0], adef}
  localparam int ID_ADEF_BIT = 0;
  localparam int ID_PC_LSB   = 1;
  localparam int ID_INST_LSB = 33;

  // branch_bus = {branch_valid, branch_pc[31:0]}
  localparam int BR_PC_LSB    = 0;
  localparam int BR_VALID_BIT = 32;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_EX     = 2'd1,
    SEL_ERTN   = 2'd2,
    SEL_BRANCH = 2'd3
  } flush_sel_e;

  // Exception beats ertn only when ertn is absent; ertn beats a branch.
  function automatic flush_sel_e flush_select(input logic wb_exception,
                                              input logic ertn,
                                              input logic br_take);
    if (wb_exception & ~ertn) return SEL_EX;
    if (ertn)                 return SEL_ERTN;
    if (br_take)              return SEL_BRANCH;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/if_fetch_iq.sv
// In-order fetch queue: circular buffer of DEPTH entries.
// An entry is allocated when its request is accepted on the bus and filled
// when its data returns; the head is presented to ID once filled.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             flush: drop every entry, reset all pointers
//   alloc_en/pc/adef  allocate an entry at the tail (adef entries arrive pre-filled)
//   fill_en/inst      write returned data at the fill pointer
//   pop               ID consumed the head this cycle
//   full              occupancy == DEPTH
//   head_valid        head allocated and filled
//   head_pc/inst/adef head entry contents
module if_fetch_iq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        alloc_en,
  input  logic [31:0] alloc_pc,
  input  logic        alloc_adef,
  input  logic        fill_en,
  input  logic [31:0] fill_inst,
  input  logic        pop,
  output logic        full,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic        head_adef
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]    pc_q   [DEPTH];
  logic [31:0]    inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [DEPTH-1:0] adef_q;

  logic [PW-1:0] head_ptr, alloc_ptr, fill_ptr;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] filled_cnt;   // filled entries not yet popped

  logic adef_fill;
  // An adef entry is born filled, so the fill pointer steps past it.
  assign adef_fill = alloc_en & alloc_adef;

  assign full       = (occupancy == CW'(DEPTH));
  assign head_valid = (occupancy != '0) & filled_q[head_ptr];
  assign head_pc    = pc_q[head_ptr];
  assign head_inst  = inst_q[head_ptr];
  assign head_adef  = adef_q[head_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_ptr   <= '0;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      occupancy  <= '0;
      filled_cnt <= '0;
      filled_q   <= '0;
      adef_q     <= '0;
    end else begin
      if (alloc_en) begin
        pc_q[alloc_ptr]     <= alloc_pc;
        inst_q[alloc_ptr]   <= '0;
        adef_q[alloc_ptr]   <= alloc_adef;
        filled_q[alloc_ptr] <= alloc_adef;
        alloc_ptr           <= alloc_ptr + PW'(1);
      end
      if (fill_en) begin
        inst_q[fill_ptr]   <= fill_inst;
        filled_q[fill_ptr] <= 1'b1;
      end
      // Pop never targets the allocated slot: alloc needs a non-full queue,
      // and pop needs a non-empty one, so the two indices differ.
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
      fill_ptr   <= fill_ptr + PW'(fill_en) + PW'(adef_fill);
      occupancy  <= occupancy + CW'(alloc_en) - CW'(pop);
      filled_cnt <= filled_cnt + CW'(fill_en) + CW'(adef_fill) - CW'(pop);
    end
  end

  a_filled_le_alloc: assert property (@(posedge clk) disable iff (reset)
    filled_cnt <= occupancy);

endmodule

// File: rtl/if_stage_fetch_queue.sv
// Instruction-fetch stage with a parametrised in-order fetch queue.
// Issues fetches on the SRAM-like bus (req/addr_ok/data_ok), buffers returns
// in if_fetch_iq and hands complete entries to ID. Flushes redirect fetch_pc,
// empty the queue, and arm cancel_cnt to discard returns of the old stream.
// Handshakes: a request transfers when inst_sram_req & inst_sram_addr_ok;
// data returns in request order, one per inst_sram_data_ok; an entry moves
// to ID when IF_to_ID_valid & ID_allow.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ID_allow                     ID takes the head entry
//   branch_bus, ID_br_stall      {branch_valid, branch_pc}; stall masks the branch
//   WB_exception/ex_entry        exception flush and target
//   ertn_flush/ertn_entry        ertn flush and target
//   IF_to_ID_valid/IF_to_ID_bus  {inst, pc, adef} to ID
//   inst_sram_*                  instruction bus
module if_stage_fetch_queue
  import if_pkg::*;
#(
  parameter int          IQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ID_allow,
  input  logic [BR_BUS_W-1:0]       branch_bus,
  input  logic                      ID_br_stall,
  input  logic                      WB_exception,
  input  logic                      ertn_flush,
  input  logic [31:0]               ex_entry,
  input  logic [31:0]               ertn_entry,
  output logic                      IF_to_ID_valid,
  output logic [IF_TO_ID_BUS_W-1:0] IF_to_ID_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [3:0]                inst_sram_wstrb,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic [OW-1:0] cancel_cnt;
  logic          adef_halt;

  logic          branch_valid, br_take, flush, aligned;
  logic [31:0]   branch_pc, flush_target;
  flush_sel_e    sel;
  logic          fire, adef_alloc, alloc_en, fill_en, pop;
  logic          iq_full, head_valid, head_adef;
  logic [31:0]   head_pc, head_inst;

  assign branch_valid = branch_bus[BR_VALID_BIT];
  assign branch_pc    = branch_bus[BR_PC_LSB +: 32];
  assign br_take      = branch_valid & ~ID_br_stall;
  assign flush        = WB_exception | ertn_flush | br_take;
  assign sel          = flush_select(WB_exception, ertn_flush, br_take);

  always_comb begin
    flush_target = branch_pc;
    case (sel)
      SEL_EX:   flush_target = ex_entry;
      SEL_ERTN: flush_target = ertn_entry;
      default:  flush_target = branch_pc;
    endcase
  end

  assign aligned = (fetch_pc[1:0] == 2'b00);

  // Registered state only: no path from ID_allow or data_ok into req.
  assign inst_sram_req = ~reset & ~adef_halt & aligned &
                         (outstanding < OW'(MAX_OUTSTANDING)) & ~iq_full;
  assign inst_sram_addr  = reset ? 32'h0 : fetch_pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign fire = inst_sram_req & inst_sram_addr_ok;

  // A misaligned PC waits for the old requests to drain so the ADEF entry
  // lands behind them in program order.
  assign adef_alloc = ~reset & ~adef_halt & ~aligned & ~flush & ~iq_full &
                      (outstanding == '0);
  assign alloc_en   = (fire & ~flush) | adef_alloc;
  assign fill_en    = ~reset & inst_sram_data_ok & (cancel_cnt == '0) & ~flush;

  assign IF_to_ID_valid = ~reset & head_valid & ~flush;
  assign pop            = IF_to_ID_valid & ID_allow;

  always_comb begin
    IF_to_ID_bus = '0;
    if (!reset) begin
      IF_to_ID_bus[ID_INST_LSB +: 32] = head_inst;
      IF_to_ID_bus[ID_PC_LSB +: 32]   = head_pc;
      IF_to_ID_bus[ID_ADEF_BIT]       = head_adef;
    end
  end

  // Handshakes in a flush cycle still count: they belong to the old stream.
  assign outstanding_nxt = outstanding + OW'(fire) - OW'(inst_sram_data_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      cancel_cnt  <= '0;
      adef_halt   <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush) begin
        fetch_pc   <= flush_target;
        cancel_cnt <= outstanding_nxt;   // every live request is now stale
        adef_halt  <= 1'b0;
      end else begin
        if (fire)       fetch_pc  <= fetch_pc + 32'd4;
        if (adef_alloc) adef_halt <= 1'b1;
        if (inst_sram_data_ok && cancel_cnt != '0)
          cancel_cnt <= cancel_cnt - OW'(1);
      end
    end
  end

  if_fetch_iq #(
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .alloc_en   (alloc_en),
    .alloc_pc   (fetch_pc),
    .alloc_adef (adef_alloc),
    .fill_en    (fill_en),
    .fill_inst  (inst_sram_rdata),
    .pop        (pop),
    .full       (iq_full),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .head_adef  (head_adef)
  );

  a_counts: assert property (@(posedge clk) disable iff (reset)
    (cancel_cnt <= outstanding) && (outstanding <= OW'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// Bench for if_stage_fetch_queue: directed scenarios plus a short random
// segment, checked every cycle against a queue-based model of the fetch stage.
module tb_if_stage_fetch_queue;
  import if_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h1c000000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ID_allow = 1'b0;
  logic [32:0] branch_bus = '0;
  logic        ID_br_stall = 1'b0, WB_exception = 1'b0, ertn_flush = 1'b0;
  logic [31:0] ex_entry = '0, ertn_entry = '0;
  logic        IF_to_ID_valid;
  logic [64:0] IF_to_ID_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;

  always #5 clk = ~clk;

  if_stage_fetch_queue #(
    .IQ_DEPTH (DEPTH), .MAX_OUTSTANDING (MAXO), .RESET_PC (RPC)
  ) dut (
    .clk (clk), .reset (reset), .ID_allow (ID_allow), .branch_bus (branch_bus),
    .ID_br_stall (ID_br_stall), .WB_exception (WB_exception), .ertn_flush (ertn_flush),
    .ex_entry (ex_entry), .ertn_entry (ertn_entry),
    .IF_to_ID_valid (IF_to_ID_valid), .IF_to_ID_bus (IF_to_ID_bus),
    .inst_sram_req (inst_sram_req), .inst_sram_wr (inst_sram_wr),
    .inst_sram_size (inst_sram_size), .inst_sram_wstrb (inst_sram_wstrb),
    .inst_sram_addr (inst_sram_addr), .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok), .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata (inst_sram_rdata)
  );

  // ---------------- stimulus variables ----------------
  logic        d_id_allow = 0, d_bv = 0, d_stall = 0, d_ex = 0, d_ertn = 0;
  logic [31:0] d_bpc = '0, d_ex_entry = '0, d_ertn_entry = '0;
  int          addr_ok_pct = 100, lat_min = 1, lat_max = 1;

  // bus responder: accepted addresses and the cycle their data comes back
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = -1;

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
    bit          adef;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = RPC;
  int          m_out = 0, m_cancel = 0;
  bit          m_halt = 0;

  // scoreboard bookkeeping
  logic [64:0] log_bus[$];     // entries ID actually took from the DUT
  int          req_seen = 0;
  int          cyc = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5a5a5a5a;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against the model for this cycle, then advance model.
  task automatic compare_and_advance();
    bit          flush, full, mreq, mvalid, fire, dok;
    logic [31:0] tgt;
    int          out_old, k, due;
    check("const_ports", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
          {1'b0, 2'b10, 4'h0, 32'h0});
    if (reset) begin
      check("reset_ctl", {inst_sram_req, IF_to_ID_valid, inst_sram_addr}, '0);
      check("reset_bus", IF_to_ID_bus, '0);
      mq.delete(); m_pc = RPC; m_out = 0; m_cancel = 0; m_halt = 0;
      pend_addr.delete(); pend_due.delete(); last_due = -1;
      return;
    end
    flush  = d_ex | d_ertn | (d_bv & ~d_stall);
    tgt    = (d_ex & ~d_ertn) ? d_ex_entry : (d_ertn ? d_ertn_entry : d_bpc);
    full   = (mq.size() == DEPTH);
    mreq   = !m_halt && (m_pc[1:0] == 2'b00) && (m_out < MAXO) && !full;
    mvalid = (mq.size() > 0) && mq[0].filled && !flush;

    check("req", inst_sram_req, mreq);
    check("addr", inst_sram_addr, m_pc);
    check("valid", IF_to_ID_valid, mvalid);
    if (mvalid) check("bus", IF_to_ID_bus, {mq[0].inst, mq[0].pc, mq[0].adef});
    if (IF_to_ID_valid && d_id_allow) log_bus.push_back(IF_to_ID_bus);
    if (inst_sram_req) req_seen++;

    // responder bookkeeping follows what actually happened on the bus
    if (inst_sram_data_ok) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (inst_sram_req && inst_sram_addr_ok) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(inst_sram_addr);
      pend_due.push_back(due);
    end

    fire    = mreq && inst_sram_addr_ok;
    dok     = inst_sram_data_ok;
    out_old = m_out;
    m_out   = m_out + int'(fire) - int'(dok);
    if (flush) begin
      m_cancel = m_out;
      mq.delete();
      m_pc   = tgt;
      m_halt = 0;
    end else begin
      if (dok) begin
        if (m_cancel > 0) m_cancel--;
        else begin
          k = -1;
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].filled) begin k = i; break; end
          if (k < 0) begin
            n_checks++; n_fail++;
            $display("FAIL data_ok_unmatched: got data_ok=1 expected no unfilled entry to exist=0 (cycle %0d)", cyc);
          end else begin
            mq[k].inst   = rdata_of(mq[k].pc);
            mq[k].filled = 1;
          end
        end
      end
      if (mvalid && d_id_allow) void'(mq.pop_front());
      if (fire) begin
        mq.push_back('{m_pc, 32'h0, 1'b0, 1'b0});
        m_pc = m_pc + 32'd4;
      end else if (m_pc[1:0] != 2'b00 && !full && out_old == 0 && !m_halt) begin
        mq.push_back('{m_pc, 32'h0, 1'b1, 1'b1});
        m_halt = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      ID_allow     = d_id_allow;
      branch_bus   = {d_bv, d_bpc};
      ID_br_stall  = d_stall;
      WB_exception = d_ex;
      ertn_flush   = d_ertn;
      ex_entry     = d_ex_entry;
      ertn_entry   = d_ertn_entry;
      if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = rdata_of(pend_addr[0]);
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = $urandom;
      end
      inst_sram_addr_ok = !reset && ($urandom_range(1, 100) <= addr_ok_pct);
      #1;
      compare_and_advance();
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    d_id_allow = 0; d_bv = 0; d_stall = 0; d_ex = 0; d_ertn = 0;
    addr_ok_pct = 100; lat_min = 1; lat_max = 1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse_branch(input logic [31:0] pc);
    d_bv = 1; d_bpc = pc; step(1); d_bv = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();

    // streaming: one instruction per cycle after the first return
    d_id_allow = 1; log_bus.delete();
    step(12);
    check("stream_count", log_bus.size(), 10);
    check("stream_pc0", log_bus[0][32:1], 32'h1c000000);
    check("stream_inst1", log_bus[1][64:33], 32'h465a5a5e);
    check("stream_pc2", log_bus[2][32:1], 32'h1c000008);

    // backpressure: queue fills to 4, then drains in order
    do_reset();
    step(8);
    check("bp_model_occ", mq.size(), 4);
    #1 check("bp_req_low", inst_sram_req, 1'b0);
    d_id_allow = 1; log_bus.delete();
    step(4);
    check("bp_drain_count", log_bus.size(), 4);
    check("bp_drain_pc3", log_bus[3][32:1], 32'h1c00000c);
    step(3);
    check("bp_resume_pc", log_bus[4][32:1], 32'h1c000010);

    // flush with two requests in flight
    do_reset();
    lat_min = 3; lat_max = 3; d_id_allow = 1;
    step(2);
    log_bus.delete();
    pulse_branch(32'h1c000100);
    check("flush_cancel", m_cancel, 2);
    step(12);
    check("flush_log_nonempty", log_bus.size() > 0, 1'b1);
    check("flush_first_pc", log_bus[0][32:1], 32'h1c000100);
    check("flush_first_inst", log_bus[0][64:33], 32'h465a5b5a);

    // target priority: exception over branch, ertn over exception
    do_reset();
    d_id_allow = 1;
    step(3);
    d_ex = 1; d_ex_entry = 32'h1c008000; d_bv = 1; d_bpc = 32'h1c000300;
    step(1);
    d_ex = 0; d_bv = 0;
    #1 check("prio_ex", inst_sram_addr, 32'h1c008000);
    step(3);
    d_ex = 1; d_ertn = 1; d_ertn_entry = 32'h1c00a000; d_bv = 1;
    step(1);
    d_ex = 0; d_ertn = 0; d_bv = 0;
    #1 check("prio_ertn", inst_sram_addr, 32'h1c00a000);
    step(3);

    // misaligned branch target
    do_reset();
    d_id_allow = 1;
    step(3);
    pulse_branch(32'h1c000102);
    log_bus.delete(); req_seen = 0;
    step(8);
    check("adef_no_req", req_seen, 0);
    check("adef_count", log_bus.size(), 1);
    check("adef_entry", log_bus[0], {32'h0, 32'h1c000102, 1'b1});
    d_ex = 1; d_ex_entry = 32'h1c000200;
    step(1);
    d_ex = 0; log_bus.delete();
    step(5);
    check("adef_resume_pc", log_bus[0][32:1], 32'h1c000200);

    // stalled branch is ignored
    do_reset();
    d_id_allow = 1;
    step(4);
    log_bus.delete();
    d_bv = 1; d_stall = 1; d_bpc = 32'h1c000400;
    step(2);
    d_bv = 0; d_stall = 0;
    step(4);
    check("stall_count", log_bus.size(), 6);
    check("stall_pc0", log_bus[0][32:1], 32'h1c000008);
    check("stall_pc5", log_bus[5][32:1], 32'h1c00001c);

    // random traffic: sporadic bus/ID readiness and redirects
    do_reset();
    addr_ok_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      d_id_allow = 1'($urandom_range(0, 1));
      d_stall    = ($urandom_range(0, 3) == 0);
      d_bv       = ($urandom_range(0, 24) == 0);
      d_bpc      = 32'h1c001000 + (32'($urandom_range(0, 63)) << 2) +
                   (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      d_ex       = ($urandom_range(0, 60) == 0);
      d_ex_entry = 32'h1c008000 + (32'($urandom_range(0, 15)) << 2);
      step(1);
    end
    d_bv = 0; d_ex = 0; d_stall = 0;
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch_queue.md
Name: if_stage_fetch_queue

Overview:
- Next-generation instruction-fetch stage. It sits between the instruction SRAM-like bus (req/addr_ok/data_ok) and the ID stage.
- It replaces the fixed two-entry instruction buffer with a parametrised in-order fetch queue that is allocated at request issue and filled at data return.
- It supports up to MAX_OUTSTANDING in-flight requests and cancels stale returns after a flush with a counter.
- A misaligned fetch PC is reported to ID as an ADEF-tagged entry and is never sent on the bus.

Parameters:
- IQ_DEPTH, 4: fetch-queue entries; power of 2, at least 2.
- MAX_OUTSTANDING, 2: maximum accepted-but-unreturned bus requests; at most IQ_DEPTH.
- RESET_PC, 32'h1c000000: first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ID_allow  in  1  ID accepts the head entry this cycle
- branch_bus  in  33  {branch_valid, branch_pc}
- ID_br_stall  in  1  suppresses branch_valid while ID is stalled
- WB_exception  in  1  exception flush
- ertn_flush  in  1  ertn flush
- ex_entry  in  32  exception target
- ertn_entry  in  32  ertn target
- IF_to_ID_valid  out  1  head entry is valid and complete
- IF_to_ID_bus  out  65  {inst[31:0], pc[31:0], adef}
- inst_sram_req  out  1  fetch request
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'b10
- inst_sram_wstrb  out  4  constant 0
- inst_sram_addr  out  32  fetch PC
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  in-order data return
- inst_sram_rdata  in  32  returned instruction

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset state:
  - fetch_pc = RESET_PC.
  - Queue empty: head, alloc and fill pointers all 0.
  - outstanding = 0, cancel_cnt = 0, adef_halt = 0.
  - All outputs are 0 while reset is high; the constant ports keep their constant values.
- Flush and redirect:
  - flush = WB_exception | ertn_flush | (branch_valid & ~ID_br_stall).
  - Target priority: WB_exception & ~ertn_flush selects ex_entry; otherwise ertn_flush selects ertn_entry; otherwise branch_pc.
- Issue:
  - inst_sram_req = ~adef_halt & (fetch_pc[1:0]==0) & (outstanding < MAX_OUTSTANDING) & (occupancy < IQ_DEPTH).
  - req uses registered counts only; there is no combinational path from ID_allow or data_ok to req.
  - inst_sram_addr = fetch_pc.
  - On addr_ok & req without flush: allocate an entry {pc=fetch_pc, filled=0, adef=0}, outstanding+1, fetch_pc+4.
- Misaligned PC:
  - Condition: fetch_pc[1:0]!=0, no flush, queue not full, outstanding==0.
  - Allocate an entry {pc, inst=0, filled=1, adef=1} and set adef_halt.
  - No further issue until the next flush.
- Return:
  - On data_ok: outstanding-1.
  - If cancel_cnt>0: cancel_cnt-1 and rdata is discarded.
  - Otherwise write rdata into the entry at the fill pointer, set filled, and advance the fill pointer.
- Output:
  - IF_to_ID_valid = head allocated & head filled & ~flush.
  - Pop when IF_to_ID_valid & ID_allow.
  - Pop and allocate may occur in the same cycle; a full queue still blocks req that cycle.
- Flush cycle:
  - fetch_pc = target. The queue is emptied: all pointers reset, entries invalidated. adef_halt is cleared.
  - cancel_cnt_next = outstanding + (req & addr_ok) − data_ok.
  - A handshake or data return in the flush cycle belongs to the old stream.
  - IF_to_ID_valid is forced to 0.
- Wrap-around: all pointers are modulo IQ_DEPTH.
- Occupancy is an explicit counter of width clog2(IQ_DEPTH)+1.
- Invariants:
  - cancel_cnt ≤ outstanding ≤ MAX_OUTSTANDING.
  - filled entries ≤ allocated entries.
  - Violating either is an assertion failure.

Decomposition:
- Shared package if_pkg:
  - IF_TO_ID_BUS_W=65, BR_BUS_W=33.
  - Field-offset constants for IF_to_ID_bus and branch_bus.
  - Flush-target select encoding.
- One sub-module, if_fetch_iq:
  - Circular buffer with allocate / fill / pop / clear.
  - Holds the pc, inst, filled and adef arrays plus the head, alloc and fill pointers and occupancy.
  - Top level keeps the PC, issue logic, outstanding/cancel counters and flush mux.

Test Plan:
- Streaming: reset, addr_ok always 1, data_ok one cycle after each accept, ID_allow=1 → ID sees pc 1c000000, 1c000004, 1c000008… one per cycle after the first return.
- Backpressure: ID_allow=0, bus always ready → exactly 4 entries allocated, req drops at occupancy 4. Raising ID_allow → the 4 instructions drain in order and issue resumes.
- Flush with in-flight requests: 2 outstanding, branch_valid=1 with branch_pc=1c000100 → cancel_cnt=2. The next 2 data_ok are dropped and the first instruction delivered has pc 1c000100.
- Exception vs ertn vs branch all in one cycle: WB_exception=1, ertn_flush=0, branch_valid=1, ex_entry=1c008000 → fetch_pc=1c008000. With ertn_flush=1 as well → ertn_entry wins.
- Misaligned branch: branch_pc=1c000102 → no req. ID receives {inst=0, pc=1c000102, adef=1} and no further req. A later ex_entry flush resumes fetch.
- ID_br_stall=1 with branch_valid=1 → no flush, stream continues unchanged.
